// File: rtl/mult_share_arbiter_if.sv
// Request/response bundle between client blocks and the shared multiplier.
// The master side issues operand requests and consumes products; the slave side is the arbiter.
interface mult_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_num1;
  logic [NUM_REQ*WIDTH-1:0] req_num2;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [2*WIDTH-1:0]       rsp_product;
  logic                     busy;
  logic [15:0]              done_count;

  modport master (
    output req_valid, req_num1, req_num2, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_product, busy, done_count
  );

  modport slave (
    input  req_valid, req_num1, req_num2, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_product, busy, done_count
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one WIDTHxWIDTH unsigned multiplier among NUM_REQ clients.
// Sequencer walks IDLE (grant) -> MUL (compute) -> HOLD (wait for consumer) -> IDLE.
module mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input  logic             clk,
  input  logic             rst,
  mult_share_arbiter_if.slave bus
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q;
  logic [ID_W-1:0]     id_q;
  logic [WIDTH-1:0]    a_q, b_q;
  logic                rsp_valid_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic [2*WIDTH-1:0]  rsp_product_q;
  logic [15:0]         done_count_q;

  logic                grant_found;
  logic [ID_W-1:0]     grant_idx;
  logic [ID_W-1:0]     cand;
  logic                do_grant;
  logic                rsp_fire;

  logic [WIDTH-1:0]    num1_arr [NUM_REQ];
  logic [WIDTH-1:0]    num2_arr [NUM_REQ];

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
    return (v == ID_W'(NUM_REQ - 1)) ? '0 : v + ID_W'(1);
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign num1_arr[i] = bus.req_num1[i*WIDTH +: WIDTH];
    assign num2_arr[i] = bus.req_num2[i*WIDTH +: WIDTH];
  end

  // Search starts at ptr so the most recently served requester is checked last.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  assign do_grant = (state_q == S_IDLE) && grant_found && !rst;
  assign rsp_fire = (state_q == S_HOLD) && bus.rsp_ready;

  always_comb begin
    state_d       = state_q;
    bus.req_ready = '0;
    unique case (state_q)
      S_IDLE: begin
        if (do_grant) begin
          bus.req_ready[grant_idx] = 1'b1;
          state_d                  = S_MUL;
        end
      end
      S_MUL:  state_d = S_HOLD;
      S_HOLD: if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and bookkeeping; an op in flight at reset is dropped with no response.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q         <= '0;
      id_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
      done_count_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (grant_found) begin
            a_q   <= num1_arr[grant_idx];
            b_q   <= num2_arr[grant_idx];
            id_q  <= grant_idx;
            ptr_q <= wrap_inc(grant_idx);
          end
        end
        S_MUL: begin
          rsp_product_q <= {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
          rsp_id_q      <= id_q;
          rsp_valid_q   <= 1'b1;
        end
        S_HOLD: begin
          if (rsp_fire) begin
            rsp_valid_q  <= 1'b0;
            done_count_q <= done_count_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_product = rsp_product_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done_count  = done_count_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: table of single-requester products plus
// hand-written sequences for backpressure, round-robin order, mid-op reset and dropped requests.
module tb_mult_share_arbiter;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   exp_done = 0;

  always #5 clk = ~clk;

  mult_share_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

  mult_share_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          idx;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_op(input int idx, input logic [7:0] a, input logic [7:0] b);
    bus.req_num1[idx*WIDTH +: WIDTH] = a;
    bus.req_num2[idx*WIDTH +: WIDTH] = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_done = 0;
  endtask

  // One full operation from a lone requester: grant, MUL, HOLD with rsp_ready high.
  task automatic run_single(input int idx, input logic [7:0] a, input logic [7:0] b,
                            input logic [15:0] prod);
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    @(negedge clk);
    bus.req_valid = onehot;
    bus.rsp_ready = 1'b1;
    set_op(idx, a, b);
    #1 check("single_grant", bus.req_ready, onehot);
    @(negedge clk);
    bus.req_valid = '0;
    check("single_mul_busy", bus.busy, 1);
    check("single_mul_novalid", bus.rsp_valid, 0);
    @(negedge clk);
    check("single_rsp_valid", bus.rsp_valid, 1);
    check("single_rsp_id", bus.rsp_id, idx);
    check("single_rsp_product", bus.rsp_product, prod);
    exp_done++;
    @(negedge clk);
    check("single_rsp_cleared", bus.rsp_valid, 0);
    check("single_done_count", bus.done_count, exp_done);
    check("single_idle", bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 8'hA0, 8'h02, 16'h0140};
    vecs[1] = '{1, 8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{2, 8'h00, 8'h5A, 16'h0000};
    vecs[3] = '{3, 8'h01, 8'h80, 16'h0080};
    vecs[4] = '{1, 8'h38, 8'h26, 16'h0850};
    vecs[5] = '{2, 8'h10, 8'h10, 16'h0100};
    vecs[6] = '{3, 8'h0F, 8'h11, 16'h00FF};
    vecs[7] = '{0, 8'h80, 8'h80, 16'h4000};

    bus.req_valid = 4'b1111;
    bus.req_num1  = '0;
    bus.req_num2  = '0;
    bus.rsp_ready = 1'b0;
    rst = 1'b1;

    // Reset state, with every requester valid so req_ready must stay forced low.
    @(negedge clk);
    @(negedge clk);
    check("reset_req_ready", bus.req_ready, 0);
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done_count", bus.done_count, 0);
    check("reset_rsp_id", bus.rsp_id, 0);
    check("reset_rsp_product", bus.rsp_product, 0);
    bus.req_valid = '0;
    rst = 1'b0;
    exp_done = 0;

    for (int v = 0; v < 8; v++) begin
      run_single(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].prod);
    end

    // Backpressure: req1 held in HOLD for 5 cycles while req2 waits.
    do_reset();
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    set_op(1, 8'h38, 8'h26);
    set_op(2, 8'h05, 8'h07);
    bus.req_valid = 4'b0110;
    #1 check("bp_grant1", bus.req_ready, 4'b0010);
    @(negedge clk);
    bus.req_valid = 4'b0100;
    check("bp_mul_ready", bus.req_ready, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", bus.rsp_valid, 1);
      check("bp_hold_product", bus.rsp_product, 16'h0850);
      check("bp_hold_id", bus.rsp_id, 1);
      check("bp_hold_ready", bus.req_ready, 0);
      check("bp_hold_busy", bus.busy, 1);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_done", bus.done_count, 1);
    check("bp_grant2", bus.req_ready, 4'b0100);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    check("bp_rsp2_id", bus.rsp_id, 2);
    check("bp_rsp2_product", bus.rsp_product, 16'h0023);
    @(negedge clk);
    check("bp_done2", bus.done_count, 2);

    // Round robin with all four continuously valid from reset.
    do_reset();
    set_op(0, 8'h03, 8'h05);
    set_op(1, 8'h11, 8'h10);
    set_op(2, 8'h7F, 8'h02);
    set_op(3, 8'hC8, 8'h03);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    begin
      int          order [5] = '{0, 1, 2, 3, 0};
      logic [15:0] prods [4] = '{16'h000F, 16'h0110, 16'h00FE, 16'h0258};
      for (int g = 0; g < 5; g++) begin
        #1 check("rr_grant", bus.req_ready, 4'b0001 << order[g]);
        @(negedge clk);
        check("rr_mul_ready", bus.req_ready, 0);
        @(negedge clk);
        check("rr_rsp_valid", bus.rsp_valid, 1);
        check("rr_rsp_id", bus.rsp_id, order[g]);
        check("rr_rsp_product", bus.rsp_product, prods[order[g]]);
        @(negedge clk);
      end
    end
    bus.req_valid = '0;
    check("rr_done", bus.done_count, 5);

    // Reset during MUL of requester 2 (ptr would otherwise be 3).
    do_reset();
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    set_op(2, 8'h09, 8'h09);
    bus.req_valid = 4'b0100;
    #1 check("rst_grant2", bus.req_ready, 4'b0100);
    @(negedge clk);
    check("rst_in_mul", bus.busy, 1);
    rst = 1'b1;
    set_op(1, 8'h12, 8'h03);
    set_op(3, 8'h02, 8'h02);
    bus.req_valid = 4'b1010;
    #1 check("rst_forces_ready_low", bus.req_ready, 0);
    @(negedge clk);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done_count", bus.done_count, 0);
    rst = 1'b0;
    #1 check("rst_grant_after", bus.req_ready, 4'b0010);
    @(negedge clk);
    bus.req_valid = 4'b1000;
    check("rst_no_stale_rsp", bus.rsp_valid, 0);
    @(negedge clk);
    check("rst_rsp_id", bus.rsp_id, 1);
    check("rst_rsp_product", bus.rsp_product, 16'h0036);
    @(negedge clk);
    check("rst_done_after", bus.done_count, 1);
    check("rst_next_grant3", bus.req_ready, 4'b1000);
    bus.req_valid = '0;

    // Requester 2 raises then drops valid while requester 0 is served.
    do_reset();
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    set_op(0, 8'h04, 8'h04);
    bus.req_valid = 4'b0001;
    #1 check("drop_grant0", bus.req_ready, 4'b0001);
    @(negedge clk);
    bus.req_valid = 4'b0100;
    #1 check("drop_mul_ready", bus.req_ready, 0);
    @(negedge clk);
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    check("drop_rsp_product", bus.rsp_product, 16'h0010);
    @(negedge clk);
    check("drop_no_grant", bus.req_ready, 0);
    check("drop_idle", bus.busy, 0);
    @(negedge clk);
    check("drop_still_idle", bus.busy, 0);
    set_op(1, 8'h06, 8'h07);
    bus.req_valid = 4'b0011;
    #1 check("drop_ptr_is_1", bus.req_ready, 4'b0010);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    check("drop_rsp_id", bus.rsp_id, 1);
    check("drop_rsp_product2", bus.rsp_product, 16'h002A);
    @(negedge clk);
    check("drop_done", bus.done_count, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
